// File: rtl/usb_wb_arb.sv
// Two-master round-robin Wishbone arbiter in front of the USB core slave port.
// One transaction at a time, with a watchdog that errors out a hung slave cycle.
module usb_wb_arb #(
  parameter int unsigned AW      = 14,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  input  logic          m0_we,
  input  logic          m0_cyc,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  input  logic          m1_we,
  input  logic          m1_cyc,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  output logic          s_we,
  output logic          s_cyc,
  input  logic          s_ack,
  output logic [1:0]    grant,
  output logic          timeout_evt
);

  localparam int unsigned CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam bit WD_EN            = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT    = 2'd1,
    ST_RETIRE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          ptr_q, ptr_d;       // 0: m0 has priority, 1: m1 has priority
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  logic in_gnt;
  logic sel_m1;
  logic m_cyc_sel;
  logic wd_fire;

  // Bus steering from the granted master; everything reads zero outside GNT.
  assign sel_m1    = grant_q[1];
  assign in_gnt    = (state_q == ST_GNT) && (grant_q != 2'b00);
  assign m_cyc_sel = sel_m1 ? m1_cyc : m0_cyc;

  assign s_cyc   = in_gnt & m_cyc_sel;
  assign s_we    = in_gnt & (sel_m1 ? m1_we : m0_we);
  assign s_addr  = in_gnt ? (sel_m1 ? m1_addr : m0_addr) : '0;
  assign s_wdata = in_gnt ? (sel_m1 ? m1_wdata : m0_wdata) : '0;

  // A slave ack in the expiring cycle takes precedence over the watchdog.
  assign wd_fire = WD_EN & s_cyc & ~s_ack & (wd_cnt_q == WD_LAST);

  assign m0_ack      = s_cyc & s_ack & grant_q[0];
  assign m1_ack      = s_cyc & s_ack & grant_q[1];
  assign m0_err      = wd_fire & grant_q[0];
  assign m1_err      = wd_fire & grant_q[1];
  assign m0_rdata    = m0_ack ? s_rdata : '0;
  assign m1_rdata    = m1_ack ? s_rdata : '0;
  assign timeout_evt = wd_fire;
  assign grant       = grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 2'b00;
      ptr_q    <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        wd_cnt_d = '0;
        if (m0_cyc && m1_cyc) begin
          grant_d = ptr_q ? 2'b10 : 2'b01;
          state_d = ST_GNT;
        end else if (m0_cyc) begin
          grant_d = 2'b01;
          state_d = ST_GNT;
        end else if (m1_cyc) begin
          grant_d = 2'b10;
          state_d = ST_GNT;
        end
      end
      ST_GNT: begin
        // Ack, abort (cyc dropped) and timeout all retire and hand priority over.
        if (!s_cyc || s_ack || wd_fire) begin
          state_d  = ST_RETIRE;
          grant_d  = 2'b00;
          ptr_d    = grant_q[0];
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end
      end
      ST_RETIRE: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = 2'b00;
        wd_cnt_d = '0;
      end
    endcase
  end

endmodule
